// File: rtl/wts_wave_ram_arbiter_pkg.sv
// Shared definitions for the wave RAM arbiter.
//   WAIT_W      width of the CPU wait counter (saturates at 15)
//   OWN_*       owner codes carried down the read tag pipe
//   GRANT_*     per-cycle grant state encodings
//   wait_inc()  saturating increment of the wait counter
package wts_wave_ram_arbiter_pkg;

    localparam int unsigned WAIT_W = 4;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_ENG  = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_CPU  = 2'd1;
    localparam logic [1:0] GRANT_ENG  = 2'd2;

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] w);
        return (&w) ? w : w + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/wts_arb_rd_pipe.sv
// Read tag delay line and output data registers for the wave RAM arbiter.
// A tag {owner, ch} enters in the grant cycle, travels two stages alongside the
// registered RAM address and the RAM read, then steers ram_q into the CPU or
// engine output register with a one-cycle valid strobe.
// Ports:
//   clk, nreset              clock, asynchronous active-low reset
//   in_own, in_ch            tag of the access granted this cycle
//   ram_q                    RAM read data (valid two cycles after grant)
//   cpu_q, cpu_q_valid       CPU read data and strobe
//   eng_q, eng_q_ch, eng_q_valid  engine read data, channel tag and strobe
module wts_arb_rd_pipe
    import wts_wave_ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CH_W   = 3
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [1:0]        in_own,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_q_valid,
    output logic [DATA_W-1:0] eng_q,
    output logic [CH_W-1:0]   eng_q_ch,
    output logic              eng_q_valid
);

    logic [1:0]      own1, own2;
    logic [CH_W-1:0] ch1, ch2;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            own1        <= OWN_NONE;
            own2        <= OWN_NONE;
            ch1         <= '0;
            ch2         <= '0;
            cpu_q       <= '0;
            cpu_q_valid <= 1'b0;
            eng_q       <= '0;
            eng_q_ch    <= '0;
            eng_q_valid <= 1'b0;
        end else begin
            own1        <= in_own;
            ch1         <= in_ch;
            own2        <= own1;
            ch2         <= ch1;
            cpu_q_valid <= (own2 == OWN_CPU);
            eng_q_valid <= (own2 == OWN_ENG);
            if (own2 == OWN_CPU) begin
                cpu_q <= ram_q;
            end
            if (own2 == OWN_ENG) begin
                eng_q    <= ram_q;
                eng_q_ch <= ch2;
            end
        end
    end

endmodule

// File: rtl/wts_wave_ram_arbiter.sv
// Single-port wave RAM arbiter between the CPU slot bus and the engine fetcher.
// One RAM access is granted per clock; the engine wins unless the pending CPU
// request has waited CPU_MAX_WAIT cycles. Reads return 3 cycles after grant.
// Optional build macro: WTS_ARB_STATS_EN adds stat_drop and stat_maxwait.
// Ports:
//   clk, nreset                      clock, asynchronous active-low reset
//   cpu_wrreq, cpu_rdreq, cpu_a, cpu_d   CPU one-cycle request pulses
//   cpu_busy, cpu_q, cpu_q_valid     CPU pending flag and read return
//   eng_req, eng_ch, eng_a, eng_ack  engine level request / combinational ack
//   eng_q, eng_q_ch, eng_q_valid     engine read return with channel tag
//   ram_a, ram_we, ram_d, ram_q      registered RAM interface
//   stat_drop, stat_maxwait          (WTS_ARB_STATS_EN only) statistics
module wts_wave_ram_arbiter
    import wts_wave_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CH_W         = 3,
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cpu_wrreq,
    input  logic              cpu_rdreq,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_d,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_q_valid,
    input  logic              eng_req,
    input  logic [CH_W-1:0]   eng_ch,
    input  logic [ADDR_W-1:0] eng_a,
    output logic              eng_ack,
    output logic [DATA_W-1:0] eng_q,
    output logic [CH_W-1:0]   eng_q_ch,
    output logic              eng_q_valid,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d
`ifdef WTS_ARB_STATS_EN
    ,
    output logic              stat_drop,
    output logic [WAIT_W-1:0] stat_maxwait
`endif
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

    logic              pending;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        grant;
    logic              cpu_pulse;
    logic [1:0]        rd_own;
    logic [CH_W-1:0]   rd_ch;

    assign cpu_pulse = cpu_wrreq | cpu_rdreq;
    assign cpu_busy  = pending;
    assign eng_ack   = (grant == GRANT_ENG);

    always_comb begin
        grant = GRANT_NONE;
        if (pending && (!eng_req || wait_cnt >= MAX_WAIT)) begin
            grant = GRANT_CPU;
        end else if (eng_req) begin
            grant = GRANT_ENG;
        end
    end

    // Only reads enter the tag pipe; a CPU write never produces a strobe.
    always_comb begin
        rd_own = OWN_NONE;
        rd_ch  = '0;
        if (grant == GRANT_CPU && !pend_wr) begin
            rd_own = OWN_CPU;
        end else if (grant == GRANT_ENG) begin
            rd_own = OWN_ENG;
            rd_ch  = eng_ch;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending  <= 1'b0;
            pend_wr  <= 1'b0;
            pend_a   <= '0;
            pend_d   <= '0;
            wait_cnt <= '0;
            ram_a    <= '0;
            ram_we   <= 1'b0;
            ram_d    <= '0;
        end else begin
            unique case (grant)
                GRANT_CPU: begin
                    pending  <= 1'b0;
                    wait_cnt <= '0;
                    ram_a    <= pend_a;
                    ram_we   <= pend_wr;
                    ram_d    <= pend_d;
                end
                GRANT_ENG: begin
                    ram_a  <= eng_a;
                    ram_we <= 1'b0;
                    if (pending) begin
                        wait_cnt <= wait_inc(wait_cnt);
                    end
                end
                default: begin
                    ram_we <= 1'b0;
                    if (pending) begin
                        wait_cnt <= wait_inc(wait_cnt);
                    end
                end
            endcase
            // Pulses arriving while a request is pending (including its grant
            // cycle) are dropped. Write wins over a simultaneous read.
            if (!pending && cpu_pulse) begin
                pending  <= 1'b1;
                pend_wr  <= cpu_wrreq;
                pend_a   <= cpu_a;
                pend_d   <= cpu_d;
                wait_cnt <= '0;
            end
        end
    end

`ifdef WTS_ARB_STATS_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stat_drop    <= 1'b0;
            stat_maxwait <= '0;
        end else begin
            if (pending && cpu_pulse) begin
                stat_drop <= 1'b1;
            end
            if (grant == GRANT_CPU && wait_cnt > stat_maxwait) begin
                stat_maxwait <= wait_cnt;
            end
        end
    end
`endif

    wts_arb_rd_pipe #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_rd_pipe (
        .clk         (clk),
        .nreset      (nreset),
        .in_own      (rd_own),
        .in_ch       (rd_ch),
        .ram_q       (ram_q),
        .cpu_q       (cpu_q),
        .cpu_q_valid (cpu_q_valid),
        .eng_q       (eng_q),
        .eng_q_ch    (eng_q_ch),
        .eng_q_valid (eng_q_valid)
    );

endmodule

// File: tb/tb_wts_wave_ram_arbiter.sv
// Bench for wts_wave_ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_wts_wave_ram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CH_W   = 3;
    localparam int MAXW   = 4;
    localparam int NC     = 4096;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              cpu_wrreq = 1'b0, cpu_rdreq = 1'b0;
    logic [ADDR_W-1:0] cpu_a = '0;
    logic [DATA_W-1:0] cpu_d = '0;
    logic              cpu_busy, cpu_q_valid;
    logic [DATA_W-1:0] cpu_q;
    logic              eng_req = 1'b0;
    logic [CH_W-1:0]   eng_ch = '0;
    logic [ADDR_W-1:0] eng_a = '0;
    logic              eng_ack, eng_q_valid;
    logic [DATA_W-1:0] eng_q;
    logic [CH_W-1:0]   eng_q_ch;
    logic [DATA_W-1:0] ram_q = '0;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_we;
    logic [DATA_W-1:0] ram_d;

    always #5 clk = ~clk;

    wts_wave_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W), .CPU_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .nreset(nreset),
        .cpu_wrreq(cpu_wrreq), .cpu_rdreq(cpu_rdreq), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_busy(cpu_busy), .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid),
        .eng_req(eng_req), .eng_ch(eng_ch), .eng_a(eng_a), .eng_ack(eng_ack),
        .eng_q(eng_q), .eng_q_ch(eng_q_ch), .eng_q_valid(eng_q_valid),
        .ram_q(ram_q), .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d)
    );

    // Synchronous single-port RAM: address sampled at the edge, data next cycle.
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Pending CPU request plus wait count; every grant schedules its visible
    // effects into per-cycle tables: RAM drive at +1, read strobe at +3.
    logic [DATA_W-1:0] mmem [1024];
    bit                m_pend, m_wr, m_pend_old, cg, eg;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;
    int                m_wt;
    bit                s_rv [NC];
    bit                s_we [NC];
    logic [ADDR_W-1:0] s_a  [NC];
    logic [DATA_W-1:0] s_d  [NC];
    bit                s_cv [NC];
    logic [DATA_W-1:0] s_cq [NC];
    bit                s_ev [NC];
    logic [DATA_W-1:0] s_eq [NC];
    logic [CH_W-1:0]   s_ech[NC];
    logic [DATA_W-1:0] h_cq, h_eq;
    logic [CH_W-1:0]   h_ech;
    bit                ack_last;

    always @(negedge clk) begin
        ack_last = eng_ack;
        if (cyc < NC - 4) begin
            if (!nreset) begin
                chk("rst_busy", cpu_busy, 0);
                chk("rst_eng_ack", eng_ack, 0);
                chk("rst_ram", {ram_we, ram_a, ram_d}, 0);
                chk("rst_cpu_q", {cpu_q_valid, cpu_q}, 0);
                chk("rst_eng_q", {eng_q_valid, eng_q_ch, eng_q}, 0);
                m_pend = 0; m_wt = 0;
                h_cq = '0; h_eq = '0; h_ech = '0;
                for (int i = cyc; i < NC; i++) begin
                    s_rv[i] = 0; s_we[i] = 0; s_cv[i] = 0; s_ev[i] = 0;
                end
            end else begin
                // A write lands in RAM at the end of the cycle it is driven.
                if (s_we[cyc]) mmem[s_a[cyc]] = s_d[cyc];
                if (s_cv[cyc]) h_cq = s_cq[cyc];
                if (s_ev[cyc]) begin h_eq = s_eq[cyc]; h_ech = s_ech[cyc]; end
                cg = m_pend && (!eng_req || m_wt >= MAXW);
                eg = !cg && eng_req;
                chk("cpu_busy", cpu_busy, m_pend);
                chk("eng_ack", eng_ack, eg);
                chk("ram_we", ram_we, s_we[cyc]);
                if (s_rv[cyc]) chk("ram_a", ram_a, s_a[cyc]);
                if (s_we[cyc]) chk("ram_d", ram_d, s_d[cyc]);
                chk("cpu_q_valid", cpu_q_valid, s_cv[cyc]);
                chk("cpu_q", cpu_q, h_cq);
                chk("eng_q_valid", eng_q_valid, s_ev[cyc]);
                chk("eng_q", eng_q, h_eq);
                chk("eng_q_ch", eng_q_ch, h_ech);
                if (cg) begin
                    s_rv[cyc+1] = 1; s_we[cyc+1] = m_wr; s_a[cyc+1] = m_a; s_d[cyc+1] = m_d;
                    if (!m_wr) begin s_cv[cyc+3] = 1; s_cq[cyc+3] = mmem[m_a]; end
                end
                if (eg) begin
                    s_rv[cyc+1] = 1; s_a[cyc+1] = eng_a;
                    s_ev[cyc+3] = 1; s_eq[cyc+3] = mmem[eng_a]; s_ech[cyc+3] = eng_ch;
                end
                m_pend_old = m_pend;
                if (cg) begin
                    m_pend = 0; m_wt = 0;
                end else if (m_pend) begin
                    m_wt = (m_wt < 15) ? m_wt + 1 : 15;
                end
                if (!m_pend_old && (cpu_wrreq || cpu_rdreq)) begin
                    m_pend = 1; m_wr = cpu_wrreq; m_a = cpu_a; m_d = cpu_d; m_wt = 0;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    int eng_mode = 0;  // 0 manual, 1 hold request cycling ch 0..4, 2 random

    task automatic step();
        @(posedge clk);
        #1;
        cpu_wrreq = 0;
        cpu_rdreq = 0;
        if (eng_mode == 1 && ack_last) begin
            eng_ch = CH_W'((int'(eng_ch) + 1) % 5);
            eng_a  = ADDR_W'($urandom_range(0, 31));
        end else if (eng_mode == 2) begin
            if (eng_req && ack_last) eng_req = $urandom_range(0, 1) != 0;
            else if (!eng_req) eng_req = $urandom_range(0, 2) == 0;
            if (!eng_req || ack_last) begin
                eng_ch = CH_W'($urandom);
                eng_a  = ADDR_W'($urandom_range(0, 31));
            end
        end
    endtask

    logic [5:0] av;

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = DATA_W'(i * 7 + 3);
            mmem[i] = DATA_W'(i * 7 + 3);
        end
        repeat (3) @(posedge clk);
        #1 nreset = 1;
        step(); step();

        // Test 1: CPU write on idle engine.
        cpu_wrreq = 1; cpu_a = 10'h012; cpu_d = 8'h5A;
        step(); @(negedge clk);
        chk("t1_busy_T1", cpu_busy, 1);
        step(); @(negedge clk);
        chk("t1_ram_we", ram_we, 1);
        chk("t1_ram_a", ram_a, 10'h012);
        chk("t1_ram_d", ram_d, 8'h5A);
        chk("t1_busy_T2", cpu_busy, 0);
        step(); step();

        // Test 2: read it back, strobe 4 cycles after the pulse.
        cpu_rdreq = 1; cpu_a = 10'h012;
        step(); step(); step(); @(negedge clk);
        chk("t2_early_valid", cpu_q_valid, 0);
        step(); @(negedge clk);
        chk("t2_valid", cpu_q_valid, 1);
        chk("t2_q", cpu_q, 8'h5A);
        step();

        // Test 3: engine holds request; CPU waits CPU_MAX_WAIT cycles.
        eng_mode = 1; eng_req = 1; eng_ch = 0; eng_a = 10'h003;
        step(); step(); step();
        cpu_rdreq = 1; cpu_a = 10'h012;
        for (int k = 0; k < 6; k++) begin
            step(); @(negedge clk);
            av[k] = eng_ack;
        end
        chk("t3_ack_pattern", av, 6'b101111);
        step(); step();
        eng_mode = 0; eng_req = 0;
        repeat (5) step();

        // Test 4: simultaneous rd+wr, then a pulse while busy.
        cpu_rdreq = 1; cpu_wrreq = 1; cpu_a = 10'h020; cpu_d = 8'h33;
        step();
        cpu_wrreq = 1; cpu_a = 10'h020; cpu_d = 8'h77;
        @(negedge clk);
        chk("t4_busy", cpu_busy, 1);
        step(); @(negedge clk);
        chk("t4_ram_we", ram_we, 1);
        chk("t4_ram_d", ram_d, 8'h33);
        step(); step(); step();
        cpu_rdreq = 1; cpu_a = 10'h020;
        repeat (4) step();
        @(negedge clk);
        chk("t4_readback", {cpu_q_valid, cpu_q}, {1'b1, 8'h33});
        step(); step();

        // Test 5: reset one cycle after an engine grant.
        eng_req = 1; eng_ch = 3'd5; eng_a = 10'h012;
        @(negedge clk);
        chk("t5_ack", eng_ack, 1);
        step();
        eng_req = 0; nreset = 0;
        @(negedge clk);
        chk("t5_rst_outs", {cpu_busy, cpu_q_valid, eng_q_valid, ram_we, ram_a}, 0);
        step();
        nreset = 1;
        av = '0;
        for (int k = 0; k < 5; k++) begin
            step(); @(negedge clk);
            av[k] = eng_q_valid;
        end
        chk("t5_no_strobe", av, 0);
        cpu_rdreq = 1; cpu_a = 10'h012;
        repeat (4) step();
        @(negedge clk);
        chk("t5_fresh_read", {cpu_q_valid, cpu_q}, {1'b1, 8'h5A});
        step();

        // Randomized traffic, with the occasional reset.
        eng_mode = 2;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!nreset) nreset = 1;
            else if ($urandom_range(0, 299) == 0) begin
                nreset = 0; eng_req = 0;
            end else begin
                case ($urandom_range(0, 5))
                    0: cpu_rdreq = 1;
                    1: cpu_wrreq = 1;
                    2: begin cpu_rdreq = 1; cpu_wrreq = 1; end
                    default: ;
                endcase
                cpu_a = ADDR_W'($urandom_range(0, 31));
                cpu_d = DATA_W'($urandom);
            end
        end
        eng_mode = 0; eng_req = 0;
        repeat (8) step();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
